// File: rtl/ram_multi_port_clear_if.sv
// Bus bundle for ram_multi_port_clear: write port, N read ports, clear request and busy flag.
interface ram_multi_port_clear_if #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned LANE_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned NUM_READ_PORTS = 2
);
    localparam int unsigned NUM_LANES = DATA_WIDTH / LANE_WIDTH;

    logic                                 iClear;
    logic [NUM_LANES-1:0]                 iWriteEnable;
    logic [ADDR_WIDTH-1:0]                iWriteAddress;
    logic [DATA_WIDTH-1:0]                iDataIn;
    logic [NUM_READ_PORTS-1:0]            iReadEnable;
    logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] iReadAddress;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] oDataOut;
    logic                                 oBusy;

    modport master (
        output iClear, iWriteEnable, iWriteAddress, iDataIn, iReadEnable, iReadAddress,
        input  oDataOut, oBusy
    );

    modport slave (
        input  iClear, iWriteEnable, iWriteAddress, iDataIn, iReadEnable, iReadAddress,
        output oDataOut, oBusy
    );
endinterface

// File: rtl/ram_multi_port_clear.sv
// Multi-read-port RAM with lane write enables, selectable read-during-write
// behaviour and a clear sequencer that fills the array after reset or on request.
module ram_multi_port_clear #(
    parameter int unsigned          DATA_WIDTH     = 16,
    parameter int unsigned          LANE_WIDTH     = 8,
    parameter int unsigned          ADDR_WIDTH     = 8,
    parameter int unsigned          DEPTH          = 256,
    parameter int unsigned          NUM_READ_PORTS = 2,
    parameter int unsigned          READ_MODE      = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
    input logic                   Clock,
    input logic                   Reset,
    ram_multi_port_clear_if.slave bus
);
    localparam int unsigned NUM_LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int unsigned IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   count_q, count_d;
    logic                   busy;

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]  dout_q [NUM_READ_PORTS];

    logic                   wr_in_range;
    logic                   wr_en;
    logic [IDX_WIDTH-1:0]   wr_idx;
    logic [DATA_WIDTH-1:0]  wr_merged;
    logic [ADDR_WIDTH-1:0]  rd_addr [NUM_READ_PORTS];
    logic [DATA_WIDTH-1:0]  rd_data [NUM_READ_PORTS];

    // Sequencer state and clear address counter.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= StClear;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next state: sweep addresses 0..DEPTH-1, restart on any clear request.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            StClear: begin
                if (bus.iClear) begin
                    count_d = '0;
                end else if (count_q == IDX_WIDTH'(DEPTH - 1)) begin
                    state_d = StIdle;
                    count_d = '0;
                end else begin
                    count_d = count_q + IDX_WIDTH'(1);
                end
            end
            StIdle: begin
                if (bus.iClear) begin
                    state_d = StClear;
                    count_d = '0;
                end
            end
            default: begin
                state_d = StClear;
                count_d = '0;
            end
        endcase
    end

    // Sequencer outputs.
    always_comb begin
        busy     = (state_q == StClear);
        bus.oBusy = busy;
    end

    // Write-port decode: lane merge of the addressed word, dropped when out of range.
    always_comb begin
        wr_in_range = 32'(bus.iWriteAddress) < DEPTH;
        wr_idx      = bus.iWriteAddress[IDX_WIDTH-1:0];
        wr_en       = !busy && (|bus.iWriteEnable) && wr_in_range;
        wr_merged   = wr_in_range ? mem_q[wr_idx] : '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (bus.iWriteEnable[k]) begin
                wr_merged[k*LANE_WIDTH +: LANE_WIDTH] = bus.iDataIn[k*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    // Read-port data selection; a colliding port sees the merged word only in write-through mode.
    always_comb begin
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            rd_addr[p] = bus.iReadAddress[p*ADDR_WIDTH +: ADDR_WIDTH];
            rd_data[p] = '0;
            if (!busy && (32'(rd_addr[p]) < DEPTH)) begin
                if ((READ_MODE == 1) && wr_en && (rd_addr[p] == bus.iWriteAddress)) begin
                    rd_data[p] = wr_merged;
                end else begin
                    rd_data[p] = mem_q[rd_addr[p][IDX_WIDTH-1:0]];
                end
            end
        end
    end

    // Storage array: clear sequencer has priority over the user write port.
    always_ff @(posedge Clock) begin
        if (busy) begin
            mem_q[count_q] <= CLEAR_VALUE;
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_merged;
        end
    end

    // Registered read outputs; a disabled port holds its last value.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int p = 0; p < NUM_READ_PORTS; p++) begin
                dout_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_READ_PORTS; p++) begin
                if (bus.iReadEnable[p]) begin
                    dout_q[p] <= rd_data[p];
                end
            end
        end
    end

    // Pack the per-port registers onto the output bus.
    always_comb begin
        bus.oDataOut = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            bus.oDataOut[p*DATA_WIDTH +: DATA_WIDTH] = dout_q[p];
        end
    end
endmodule

// File: tb/tb_ram_multi_port_clear.sv
// Self-checking bench: two instances (read-old and write-through) share one stimulus
// stream and are compared against an array-based reference model every cycle.
module tb_ram_multi_port_clear;
    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 8;
    localparam int unsigned DEP = 16;
    localparam logic [15:0] CV  = 16'hA5A5;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    ram_multi_port_clear_if #(.DATA_WIDTH(DW), .LANE_WIDTH(8), .ADDR_WIDTH(AW),
                              .NUM_READ_PORTS(2)) if0 ();
    ram_multi_port_clear_if #(.DATA_WIDTH(DW), .LANE_WIDTH(8), .ADDR_WIDTH(AW),
                              .NUM_READ_PORTS(2)) if1 ();

    assign if1.iClear        = if0.iClear;
    assign if1.iWriteEnable  = if0.iWriteEnable;
    assign if1.iWriteAddress = if0.iWriteAddress;
    assign if1.iDataIn       = if0.iDataIn;
    assign if1.iReadEnable   = if0.iReadEnable;
    assign if1.iReadAddress  = if0.iReadAddress;

    ram_multi_port_clear #(.DATA_WIDTH(DW), .LANE_WIDTH(8), .ADDR_WIDTH(AW), .DEPTH(DEP),
                           .NUM_READ_PORTS(2), .READ_MODE(0), .CLEAR_VALUE(CV))
        dut0 (.Clock(Clock), .Reset(Reset), .bus(if0));
    ram_multi_port_clear #(.DATA_WIDTH(DW), .LANE_WIDTH(8), .ADDR_WIDTH(AW), .DEPTH(DEP),
                           .NUM_READ_PORTS(2), .READ_MODE(1), .CLEAR_VALUE(CV))
        dut1 (.Clock(Clock), .Reset(Reset), .bus(if1));

    int tests = 0;
    int fails = 0;

    // Reference model: plain array, clear position, expected outputs [mode][port].
    logic [15:0] mem_m [DEP];
    int unsigned clr_pos;
    logic [15:0] exp_d [2][2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        clr_pos = 0;
        for (int m = 0; m < 2; m++) for (int p = 0; p < 2; p++) exp_d[m][p] = '0;
    endtask

    // Apply the behavioural rules for one rising edge using the currently driven inputs.
    task automatic model_edge();
        logic [15:0] new_w;
        logic [7:0]  ra;
        int unsigned wa;
        bit          wr_ok;
        wa = int'(if0.iWriteAddress);
        if (clr_pos < DEP) begin
            for (int p = 0; p < 2; p++) begin
                if (if0.iReadEnable[p]) begin
                    exp_d[0][p] = '0;
                    exp_d[1][p] = '0;
                end
            end
            mem_m[clr_pos] = CV;
            clr_pos = if0.iClear ? 0 : clr_pos + 1;
        end else begin
            wr_ok = (if0.iWriteEnable != 2'b00) && (wa < DEP);
            new_w = '0;
            if (wr_ok) begin
                new_w = mem_m[wa];
                if (if0.iWriteEnable[0]) new_w[7:0]  = if0.iDataIn[7:0];
                if (if0.iWriteEnable[1]) new_w[15:8] = if0.iDataIn[15:8];
            end
            for (int p = 0; p < 2; p++) begin
                ra = if0.iReadAddress[p*AW +: AW];
                if (if0.iReadEnable[p]) begin
                    if (int'(ra) >= DEP) begin
                        exp_d[0][p] = '0;
                        exp_d[1][p] = '0;
                    end else begin
                        exp_d[0][p] = mem_m[ra];
                        exp_d[1][p] = (wr_ok && int'(ra) == wa) ? new_w : mem_m[ra];
                    end
                end
            end
            if (wr_ok) mem_m[wa] = new_w;
            if (if0.iClear) clr_pos = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_busy0"}, 32'(if0.oBusy), 32'(clr_pos < DEP));
        chk({tag, "_busy1"}, 32'(if1.oBusy), 32'(clr_pos < DEP));
        chk({tag, "_m0p0"}, 32'(if0.oDataOut[15:0]),  32'(exp_d[0][0]));
        chk({tag, "_m0p1"}, 32'(if0.oDataOut[31:16]), 32'(exp_d[0][1]));
        chk({tag, "_m1p0"}, 32'(if1.oDataOut[15:0]),  32'(exp_d[1][0]));
        chk({tag, "_m1p1"}, 32'(if1.oDataOut[31:16]), 32'(exp_d[1][1]));
    endtask

    task automatic drive(input logic clr, input logic [1:0] we, input logic [7:0] wa,
                         input logic [15:0] din, input logic [1:0] re,
                         input logic [7:0] ra0, input logic [7:0] ra1);
        if0.iClear        = clr;
        if0.iWriteEnable  = we;
        if0.iWriteAddress = wa;
        if0.iDataIn       = din;
        if0.iReadEnable   = re;
        if0.iReadAddress  = {ra1, ra0};
    endtask

    task automatic tick(input string tag);
        @(posedge Clock);
        model_edge();
        #1;
        check_all(tag);
        @(negedge Clock);
    endtask

    // Count edges until busy drops, bounded.
    task automatic wait_clear(input string tag, output int n);
        n = 0;
        do begin
            drive(1'b0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 15)), 16'($urandom),
                  2'b11, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)));
            tick(tag);
            n++;
        end while (if0.oBusy && n < 100);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #2 Reset = 1'b0;
        #1;
        chk("rst_async_busy0", 32'(if0.oBusy), 32'd1);
        chk("rst_async_busy1", 32'(if1.oBusy), 32'd1);
        chk("rst_async_dout0", 32'(if0.oDataOut), 32'd0);
        chk("rst_async_dout1", 32'(if1.oDataOut), 32'd0);
        model_reset();
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    initial begin
        int n;
        drive(1'b0, 2'b00, 8'd0, 16'd0, 2'b00, 8'd0, 8'd0);
        model_reset();
        #12;
        check_all("reset");

        // Power-up clear length, then outputs stay 0 until the first enabled read.
        @(negedge Clock);
        Reset = 1'b1;
        drive(1'b0, 2'b00, 8'd0, 16'd0, 2'b00, 8'd0, 8'd0);
        n = 0;
        do begin tick("clr"); n++; end while (if0.oBusy && n < 100);
        chk("clear_len", 32'(n), 32'd16);
        chk("dout_zero_after_clear", 32'(if0.oDataOut), 32'd0);
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 2'b00, 8'd0, 16'd0, 2'b11, 8'(a), 8'(15 - a));
            tick("rd_clear");
            chk("rd_clear_val", 32'(if0.oDataOut[15:0]), 32'hA5A5);
        end

        // Lane-masked write.
        drive(1'b0, 2'b11, 8'd3, 16'h1234, 2'b00, 8'd0, 8'd0);
        tick("wr_full");
        drive(1'b0, 2'b01, 8'd3, 16'hFFFF, 2'b00, 8'd0, 8'd0);
        tick("wr_lane");
        drive(1'b0, 2'b00, 8'd0, 16'd0, 2'b01, 8'd3, 8'd0);
        tick("rd_lane");
        chk("lane_merge", 32'(if0.oDataOut[15:0]), 32'h12FF);

        // Read-during-write collision.
        drive(1'b0, 2'b11, 8'd5, 16'h0001, 2'b00, 8'd0, 8'd0);
        tick("wr5");
        drive(1'b0, 2'b11, 8'd5, 16'hBEEF, 2'b11, 8'd5, 8'd5);
        tick("coll");
        chk("coll_m0", 32'(if0.oDataOut), 32'h0001_0001);
        chk("coll_m1", 32'(if1.oDataOut), 32'hBEEF_BEEF);
        drive(1'b0, 2'b00, 8'd0, 16'd0, 2'b11, 8'd5, 8'd5);
        tick("after_coll");
        chk("after_coll_m0", 32'(if0.oDataOut), 32'hBEEF_BEEF);
        chk("after_coll_m1", 32'(if1.oDataOut), 32'hBEEF_BEEF);

        // Out-of-range write/read, then hold with read disabled.
        drive(1'b0, 2'b11, 8'd16, 16'hDEAD, 2'b00, 8'd0, 8'd0);
        tick("oor_wr");
        drive(1'b0, 2'b00, 8'd0, 16'd0, 2'b11, 8'd16, 8'd0);
        tick("oor_rd");
        chk("oor_rd_zero", 32'(if0.oDataOut[15:0]), 32'd0);
        chk("oor_alias0", 32'(if0.oDataOut[31:16]), 32'hA5A5);
        drive(1'b0, 2'b00, 8'd0, 16'd0, 2'b01, 8'd3, 8'd0);
        tick("rd3");
        drive(1'b0, 2'b00, 8'd0, 16'd0, 2'b00, 8'd5, 8'd5);
        tick("hold");
        chk("hold_val", 32'(if0.oDataOut[15:0]), 32'h12FF);

        // Clear request while writing address 2.
        drive(1'b1, 2'b11, 8'd2, 16'h7777, 2'b00, 8'd0, 8'd0);
        tick("clr_req");
        wait_clear("clr_busy", n);
        chk("clr_req_len", 32'(n), 32'd16);
        drive(1'b0, 2'b00, 8'd0, 16'd0, 2'b01, 8'd2, 8'd0);
        tick("rd2");
        chk("rd2_cleared", 32'(if0.oDataOut[15:0]), 32'hA5A5);

        // Reset at clear counter 7 restarts a full clear.
        drive(1'b1, 2'b00, 8'd0, 16'd0, 2'b00, 8'd0, 8'd0);
        tick("clr_req2");
        drive(1'b0, 2'b00, 8'd0, 16'd0, 2'b00, 8'd0, 8'd0);
        for (int i = 0; i < 7; i++) tick("pre_rst");
        async_reset();
        wait_clear("rst_clr", n);
        chk("rst_clr_len", 32'(n), 32'd16);

        // Clear request at counter 4 restarts the count.
        drive(1'b1, 2'b00, 8'd0, 16'd0, 2'b00, 8'd0, 8'd0);
        tick("clr_req3");
        drive(1'b0, 2'b00, 8'd0, 16'd0, 2'b00, 8'd0, 8'd0);
        for (int i = 0; i < 4; i++) tick("pre_restart");
        drive(1'b1, 2'b00, 8'd0, 16'd0, 2'b00, 8'd0, 8'd0);
        tick("restart");
        wait_clear("restart_clr", n);
        chk("restart_len", 32'(n), 32'd16);

        // Randomised traffic with frequent collisions and occasional clears.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] wa, ra0, ra1;
            wa  = 8'($urandom_range(0, 19));
            ra0 = ($urandom_range(0, 1) == 0) ? wa : 8'($urandom_range(0, 19));
            ra1 = ($urandom_range(0, 1) == 0) ? wa : 8'($urandom_range(0, 19));
            drive(($urandom_range(0, 63) == 0), 2'($urandom_range(0, 3)), wa, 16'($urandom),
                  2'($urandom_range(0, 3)), ra0, ra1);
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ram_multi_port_clear.md
# ram_multi_port_clear

Parametrised successor to the team's single- and dual-read-port RAMs. It provides synchronous storage with N registered read ports, one write port with per-lane write enables, selectable read-during-write behaviour, and a hardware clear sequencer. The clear sequencer fills every word with a constant after reset or on request. It serves as the VGA text/frame buffer and the CPU register/instruction store where the address/data bus widths and port count differ per instance.

## Interface
- DATA_WIDTH, 16, word width in bits; must be a multiple of LANE_WIDTH
- LANE_WIDTH, 8, bits per write-enable lane; NUM_LANES = DATA_WIDTH/LANE_WIDTH
- ADDR_WIDTH, 8, address width
- DEPTH, 256, number of words (addresses 0..DEPTH-1); DEPTH <= 2**ADDR_WIDTH
- NUM_READ_PORTS, 2, number of independent read ports (>=1)
- READ_MODE, 0, 0 = read-old-data on same-address collision, 1 = write-through (new data forwarded)
- CLEAR_VALUE, 0, word written to every address by the clear sequencer
- Clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-low reset
- iClear  in  1  single-cycle request to start (or restart) a memory clear
- iWriteEnable  in  NUM_LANES  per-lane write enable; lane k covers bits [k*LANE_WIDTH +: LANE_WIDTH]
- iWriteAddress  in  ADDR_WIDTH  write address
- iDataIn  in  DATA_WIDTH  write data
- iReadEnable  in  NUM_READ_PORTS  per-port read enable
- iReadAddress  in  NUM_READ_PORTS*ADDR_WIDTH  port p address at [p*ADDR_WIDTH +: ADDR_WIDTH]
- oDataOut  out  NUM_READ_PORTS*DATA_WIDTH  port p data at [p*DATA_WIDTH +: DATA_WIDTH], registered
- oBusy  out  1  high while clear sequencer is active; user writes/reads are not serviced

## Operation
- FSM states: CLEAR, IDLE. Reset asserted forces CLEAR and clear counter = 0. Array contents are not reset; the sequencer overwrites them.
- CLEAR: each cycle writes CLEAR_VALUE to Ram[counter], counter increments. The cycle that writes DEPTH-1 transitions to IDLE. iClear during CLEAR restarts counter at 0 and stays in CLEAR.
- IDLE: iClear=1 moves to CLEAR with counter=0 next cycle. The write in that same cycle is still performed, and is then overwritten by the clear.
- Writes (IDLE only): each lane with iWriteEnable[k]=1 updates its slice of Ram[iWriteAddress]. Lanes with 0 keep their old value. All-zero enable is no write.
- Out-of-range addresses (>= DEPTH): writes are dropped; reads return 0.
- Reads (IDLE only): a port with iReadEnable[p]=1 loads oDataOut[p] with Ram[iReadAddress[p]] at the edge. With iReadEnable[p]=0, oDataOut[p] holds its value.
- Collision (read address == write address, write enabled in same cycle):
  - READ_MODE=0: output the pre-write word.
  - READ_MODE=1: output the merged word, with enabled lanes from iDataIn and the rest old.
  - Applies to every colliding port independently.
- While oBusy=1: user writes are ignored and enabled read ports load 0.

## Timing
- Reset values: oDataOut = 0 on all ports, oBusy = 1, FSM = CLEAR, counter = 0.
- Reset assertion takes effect immediately (asynchronous) and may occur mid-clear or mid-write. The clear restarts from 0 after release.
- Clear duration: DEPTH cycles from the first rising edge after reset release (or after the iClear edge). oBusy falls after the edge that writes address DEPTH-1, so the first user access is serviced on the next edge.
- Read latency: 1 cycle (address at edge n, data valid after edge n).
- Write-then-read of the same address on consecutive cycles returns the new data in both modes.
- Port count, lanes and depth are pure elaboration parameters; no runtime mode changes.

## Test plan
- Reset, DEPTH=16, CLEAR_VALUE=16'hA5A5 -> oBusy high exactly 16 cycles after release; afterwards, reads of addresses 0..15 return 16'hA5A5 and oDataOut stays 0 until the first enabled read.
- Write 16'h1234 to address 3 with iWriteEnable=2'b11, then 16'hFFFF with 2'b01 -> port 0 read of address 3 returns 16'h12FF one cycle after issue.
- READ_MODE=0 vs 1: Ram[5]=16'h0001, same-cycle write 16'hBEEF (2'b11) and read of address 5 on both ports -> mode 0 returns 16'h0001 on both; mode 1 returns 16'hBEEF on both; the next read returns 16'hBEEF.
- iClear pulse in IDLE while writing address 2 -> oBusy high for DEPTH cycles; writes during busy are dropped; address 2 then reads CLEAR_VALUE.
- Reset asserted at clear counter=7 and released -> full DEPTH-cycle clear restarts from address 0; iClear at counter=4 likewise restarts the count.
- Write to address DEPTH (out of range) with DEPTH < 2**ADDR_WIDTH -> no array change; read of the same address returns 0; iReadEnable=0 holds the previous oDataOut.
